// File: rtl/fp_hs_pkg.sv
// Shared definitions for the strobe/acknowledge initiator family:
// FSM state encoding and default datapath/watchdog sizing.
package fp_hs_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } state_e;

endpackage

// File: rtl/hs_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and
// flags when the count reaches TIMEOUT.
module hs_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = (cnt_q == CW'(TIMEOUT));

   // Saturate at TIMEOUT so a missed abort can never wrap back to a small count.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fp_stb_initiator.sv
// Initiator bridging a valid/ready operand stream onto a stb/ack arithmetic
// unit and returning its result on a valid/ready stream, with abort watchdog.
module fp_stb_initiator
   import fp_hs_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] unit_a,
   output logic             unit_a_stb,
   input  logic             unit_a_ack,
   output logic [WIDTH-1:0] unit_b,
   output logic             unit_b_stb,
   input  logic             unit_b_ack,
   input  logic [WIDTH-1:0] unit_z,
   input  logic             unit_z_stb,
   output logic             unit_z_ack,
   output logic [WIDTH-1:0] out_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err_timeout,
   output logic             busy,
   output logic [15:0]      op_count
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
   logic             a_stb_q, a_stb_d, b_stb_q, b_stb_d;
   logic             z_ack_q, z_ack_d, out_valid_q, out_valid_d;
   logic             err_q, err_d, in_ready_q, in_ready_d, busy_q, busy_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             a_left, b_left;
   logic             wd_enable, wd_expired;

   assign wd_enable = (state_q == SEND) || (state_q == WAIT);

   hs_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (!wd_enable),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // An operand is still outstanding if its strobe is up and this edge does not ack it.
   assign a_left = a_stb_q && !unit_a_ack;
   assign b_left = b_stb_q && !unit_b_ack;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      z_d         = z_q;
      a_stb_d     = a_stb_q;
      b_stb_d     = b_stb_q;
      z_ack_d     = z_ack_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = in_a;
               b_d     = in_b;
               a_stb_d = 1'b1;
               b_stb_d = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            // Completion outranks a simultaneous watchdog expiry.
            if (!a_left && !b_left) begin
               a_stb_d = 1'b0;
               b_stb_d = 1'b0;
               z_ack_d = 1'b1;
               state_d = WAIT;
            end else if (wd_expired) begin
               a_stb_d = 1'b0;
               b_stb_d = 1'b0;
               z_ack_d = 1'b0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               a_stb_d = a_left;
               b_stb_d = b_left;
            end
         end
         WAIT: begin
            if (z_ack_q && unit_z_stb) begin
               z_d         = unit_z;
               z_ack_d     = 1'b0;
               out_valid_d = 1'b1;
               cnt_d       = cnt_q + 16'd1;
               state_d     = OUT;
            end else if (wd_expired) begin
               z_ack_d = 1'b0;
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         OUT: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         z_q         <= '0;
         a_stb_q     <= 1'b0;
         b_stb_q     <= 1'b0;
         z_ack_q     <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         z_q         <= z_d;
         a_stb_q     <= a_stb_d;
         b_stb_q     <= b_stb_d;
         z_ack_q     <= z_ack_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign unit_a      = a_q;
   assign unit_a_stb  = a_stb_q;
   assign unit_b      = b_q;
   assign unit_b_stb  = b_stb_q;
   assign unit_z_ack  = z_ack_q;
   assign out_z       = z_q;
   assign out_valid   = out_valid_q;
   assign err_timeout = err_q;
   assign busy        = busy_q;
   assign op_count    = cnt_q;

endmodule

// File: tb/tb_fp_stb_initiator.sv
// Directed bench for fp_stb_initiator (TIMEOUT=8) with a configurable
// stb/ack unit responder and a result scoreboard.
module tb_fp_stb_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_a, in_b, unit_a, unit_b, unit_z, out_z;
   logic        in_valid, in_ready, unit_a_stb, unit_a_ack, unit_b_stb, unit_b_ack;
   logic        unit_z_stb, unit_z_ack, out_valid, out_ready, err_timeout, busy;
   logic [15:0] op_count;

   int checks = 0;
   int errors = 0;

   // responder configuration
   int          a_lat = 0, b_lat = 0, z_lat = 0;
   bit          z_never = 0;
   logic [31:0] resp_z = '0;

   // monitor totals
   int a_cyc = 0, b_cyc = 0, viol_b = 0, viol_z = 0, viol_order = 0, err_cnt = 0, outv_rise = 0;

   logic [31:0] exp_q[$];

   fp_stb_initiator #(.WIDTH(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
      .unit_a(unit_a), .unit_a_stb(unit_a_stb), .unit_a_ack(unit_a_ack),
      .unit_b(unit_b), .unit_b_stb(unit_b_stb), .unit_b_ack(unit_b_ack),
      .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
      .out_z(out_z), .out_valid(out_valid), .out_ready(out_ready),
      .err_timeout(err_timeout), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Unit model: acks after a programmable number of strobe cycles, returns
   // resp_z after z_lat cycles of unit_z_ack, drops stb once the ack goes away.
   initial begin
      int a_cnt, b_cnt, z_cnt;
      a_cnt = 0; b_cnt = 0; z_cnt = 0;
      unit_a_ack = 0; unit_b_ack = 0; unit_z_stb = 0; unit_z = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            a_cnt = 0; b_cnt = 0; z_cnt = 0;
            unit_a_ack = 0; unit_b_ack = 0; unit_z_stb = 0;
         end else begin
            if (unit_a_stb) begin unit_a_ack = (a_cnt >= a_lat); a_cnt++; end
            else begin unit_a_ack = 0; a_cnt = 0; end
            if (unit_b_stb) begin unit_b_ack = (b_cnt >= b_lat); b_cnt++; end
            else begin unit_b_ack = 0; b_cnt = 0; end
            if (unit_z_stb && !unit_z_ack) begin
               unit_z_stb = 0; z_cnt = 0;
            end else if (unit_z_ack && !unit_z_stb && !z_never) begin
               if (z_cnt == z_lat) begin unit_z_stb = 1; unit_z = resp_z; end
               else z_cnt++;
            end else if (!unit_z_ack) begin
               z_cnt = 0;
            end
         end
      end
   end

   // Protocol monitor: strobe widths, data stability and pulse counts.
   initial begin
      logic        pb_stb, pz_v, pz_r, pz_ack, p_err;
      logic [31:0] pb, pz;
      pb_stb = 0; pz_v = 0; pz_r = 0; pz_ack = 0; p_err = 0; pb = '0; pz = '0;
      forever begin
         @(negedge clk);
         if (unit_a_stb) a_cyc++;
         if (unit_b_stb) b_cyc++;
         if (unit_b_stb && pb_stb && unit_b !== pb) viol_b++;
         if (out_valid && pz_v && !pz_r && out_z !== pz) viol_z++;
         if (unit_z_ack && (unit_a_stb || unit_b_stb)) viol_order++;
         if (unit_z_ack && !pz_ack && pb_stb === 1'b0 && b_cyc == 0) viol_order++;
         if (err_timeout && !p_err) err_cnt++;
         if (out_valid && !pz_v) outv_rise++;
         pb_stb = unit_b_stb; pb = unit_b; pz_v = out_valid; pz_r = out_ready;
         pz = out_z; pz_ack = unit_z_ack; p_err = err_timeout;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
      in_a = a; in_b = b; in_valid = 1;
      for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
      chk("accept_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 0;
      $display("send a=%h b=%h", a, b);
   endtask

   task automatic collect(input string tag);
      logic [31:0] e;
      for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 32'hDEAD_BEEF;
      chk({tag, "_z"}, out_z, e);
      $display("%s out_z=%h expected=%h op_count=%0d", tag, out_z, e, op_count);
   endtask

   initial begin
      int a0, b0, e0, o0, n, ir_seen, stb_seen;
      rst = 1; in_valid = 0; in_a = '0; in_b = '0; out_ready = 1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_op_count", {16'b0, op_count}, 32'd0);
      chk("rst_stbs", {29'b0, unit_a_stb, unit_b_stb, out_valid}, 32'd0);
      rst = 0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // basic 2.0 * 3.0
      a_lat = 0; b_lat = 0; z_lat = 1; resp_z = 32'h40C0_0000;
      a0 = a_cyc; b0 = b_cyc;
      send_pair(32'h4000_0000, 32'h4040_0000);
      exp_q.push_back(32'h40C0_0000);
      chk("basic_unit_a", unit_a, 32'h4000_0000);
      collect("basic");
      chk("basic_op_count", {16'b0, op_count}, 32'd1);
      chk("basic_a_stb_cycles", a_cyc - a0, 32'd1);
      chk("basic_b_stb_cycles", b_cyc - b0, 32'd1);
      @(negedge clk);
      chk("basic_valid_drop", {31'b0, out_valid}, 32'd0);

      // skewed operand acks
      a_lat = 0; b_lat = 4; z_lat = 0; resp_z = 32'h4110_0000;
      a0 = a_cyc; b0 = b_cyc;
      send_pair(32'h4040_0000, 32'h4040_0001);
      exp_q.push_back(32'h4110_0000);
      collect("skew");
      chk("skew_a_stb_cycles", a_cyc - a0, 32'd1);
      chk("skew_b_stb_cycles", b_cyc - b0, 32'd5);
      chk("skew_b_stable", viol_b, 32'd0);
      chk("skew_wait_order", viol_order, 32'd0);
      chk("skew_op_count", {16'b0, op_count}, 32'd2);
      @(negedge clk);

      // downstream backpressure with a second pair waiting
      a_lat = 0; b_lat = 0; z_lat = 0; resp_z = 32'h3F80_0000; out_ready = 0;
      send_pair(32'h3F80_0000, 32'h3F80_0000);
      exp_q.push_back(32'h3F80_0000);
      for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
      resp_z = 32'h4080_0000;
      in_a = 32'h4000_0001; in_b = 32'h4000_0002; in_valid = 1;
      ir_seen = 0; stb_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready) ir_seen++;
         if (unit_a_stb) stb_seen++;
         @(negedge clk);
      end
      chk("bp_in_ready_low", ir_seen, 32'd0);
      chk("bp_no_new_stb", stb_seen, 32'd0);
      chk("bp_out_z_stable", viol_z, 32'd0);
      collect("bp_first");
      out_ready = 1;
      for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
      @(negedge clk);
      in_valid = 0;
      exp_q.push_back(32'h4080_0000);
      chk("bp_second_accept_a", unit_a, 32'h4000_0001);
      collect("bp_second");
      chk("bp_op_count", {16'b0, op_count}, 32'd4);
      @(negedge clk);

      // unit never returns a result
      z_never = 1;
      e0 = err_cnt; o0 = outv_rise;
      send_pair(32'h1111_1111, 32'h2222_2222);
      n = 0;
      while (!err_timeout && n < 40) begin @(negedge clk); n++; end
      chk("to_err_seen", {31'b0, err_timeout}, 32'd1);
      chk("to_abort_cycle", n, 32'd9);
      chk("to_in_ready", {31'b0, in_ready}, 32'd1);
      chk("to_acks_low", {29'b0, unit_a_stb, unit_b_stb, unit_z_ack}, 32'd0);
      chk("to_op_count", {16'b0, op_count}, 32'd4);
      @(negedge clk);
      chk("to_err_pulse", {31'b0, err_timeout}, 32'd0);
      chk("to_err_count", err_cnt - e0, 32'd1);
      chk("to_no_output", outv_rise - o0, 32'd0);
      $display("timeout abort after %0d cycles", n);

      // result on the exact expiry edge wins
      z_never = 0; z_lat = 7; resp_z = 32'h4248_0000;
      e0 = err_cnt;
      send_pair(32'h4120_0000, 32'h40A0_0000);
      exp_q.push_back(32'h4248_0000);
      collect("edge");
      chk("edge_no_err", err_cnt - e0, 32'd0);
      chk("edge_op_count", {16'b0, op_count}, 32'd5);
      @(negedge clk);

      // reset while waiting for the result
      z_never = 1;
      send_pair(32'h5555_5555, 32'h6666_6666);
      for (int i = 0; i < 20 && !unit_z_ack; i++) @(negedge clk);
      chk("rw_in_wait", {31'b0, unit_z_ack}, 32'd1);
      rst = 1;
      @(negedge clk);
      chk("rw_op_count", {16'b0, op_count}, 32'd0);
      chk("rw_ctrl_zero", {26'b0, in_ready, busy, unit_a_stb, unit_b_stb, unit_z_ack, out_valid}, 32'd0);
      chk("rw_data_zero", unit_a | unit_b | out_z, 32'd0);
      chk("rw_err_zero", {31'b0, err_timeout}, 32'd0);
      rst = 0; z_never = 0; z_lat = 0; resp_z = 32'h7777_0000;
      @(negedge clk);
      send_pair(32'h0000_0001, 32'h0000_0002);
      exp_q.push_back(32'h7777_0000);
      collect("post_rst");
      chk("post_rst_op_count", {16'b0, op_count}, 32'd1);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/fp_stb_initiator.md
# fp_stb_initiator

Initiator-side controller for the team's strobe/acknowledge arithmetic-unit protocol. It takes operand pairs from an upstream valid/ready stream and drives them onto a stb/ack unit's two operand ports, such as the single-precision multiplier. It collects the unit's result through the unit's stb/ack result port and presents it downstream on a valid/ready stream. A watchdog aborts any transaction the unit fails to complete.

## Interface
Parameters:
- WIDTH, 32: operand/result width.
- TIMEOUT, 255: maximum cycles spent in SEND+WAIT before abort; minimum 2.
- CW, $clog2(TIMEOUT+1): watchdog counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_a  in  WIDTH  operand A from upstream.
- in_b  in  WIDTH  operand B from upstream.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  block can accept a pair.
- unit_a  out  WIDTH  operand A to unit.
- unit_a_stb  out  1  operand A strobe.
- unit_a_ack  in  1  unit accepted A.
- unit_b  out  WIDTH  operand B to unit.
- unit_b_stb  out  1  operand B strobe.
- unit_b_ack  in  1  unit accepted B.
- unit_z  in  WIDTH  unit result.
- unit_z_stb  in  1  unit result strobe.
- unit_z_ack  out  1  block accepts result.
- out_z  out  WIDTH  result to downstream.
- out_valid  out  1  out_z valid.
- out_ready  in  1  downstream accepts.
- err_timeout  out  1  one-cycle pulse on watchdog abort.
- busy  out  1  state != IDLE.
- op_count  out  16  completed unit transactions, wraps 0xFFFF->0x0000.

## Operation
- Protocol rule, both directions: a transfer occurs on a rising edge where stb and ack are both high. The strobing side holds stb and data stable until that transfer.
- All outputs are registered. The FSM has states IDLE, SEND, WAIT and OUT.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_a/in_b into unit_a/unit_b, raise both unit_a_stb and unit_b_stb, clear the watchdog, and go to SEND.
- SEND: each stb drops independently the cycle after its own transfer. When both have transferred, possibly on the same edge or on different edges, go to WAIT with unit_z_ack=1.
- WAIT: unit_z_ack held high. On a z transfer, capture unit_z into out_z, drop unit_z_ack, set out_valid=1, increment op_count, and go to OUT.
- OUT: out_valid held high with out_z stable. On out_valid&&out_ready, out_valid=0 and go to IDLE.
- Watchdog: increments every cycle in SEND/WAIT. When it equals TIMEOUT at an edge with no completing transfer, it does the following next cycle:
  - drop every stb and ack;
  - pulse err_timeout;
  - go to IDLE;
  - produce no output;
  - leave op_count unchanged.
- Simultaneous events: a z transfer (WAIT) or final operand transfer (SEND) on the same edge as the timeout takes priority, and no error is raised.
- unit_z_stb asserted outside WAIT is ignored; unit_z_ack stays low.

## Timing
- Reset value of every output is 0, including in_ready. in_ready=1 from the first cycle after rst deasserts.
- rst mid-transaction: on the next cycle, state=IDLE, all stb/ack/valid=0, data registers=0, op_count=0, and the watchdog is cleared.
- Latencies:
  - accept edge -> stb high next cycle;
  - operand transfer edge -> stb low next cycle;
  - last operand transfer -> unit_z_ack high next cycle;
  - z transfer -> out_valid high next cycle.
- With a zero-wait unit and an always-ready downstream, throughput is one pair per 4 cycles.

## Structure
- Package fp_hs_pkg holds:
  - the state enum {IDLE, SEND, WAIT, OUT};
  - the default WIDTH (32) and TIMEOUT (255) constants.
- One sub-module, hs_watchdog: a CW-bit counter with clear/enable inputs and an expired output, reused by other initiators.

## Test plan
- Accept 0x40000000 / 0x40400000 with a responder model that acks immediately and returns 0x40C00000 two cycles later. Required response: out_z=0x40C00000, op_count=1, unit_a_stb and unit_b_stb each high exactly 1 cycle.
- Skewed acks: A acked at cycle 1, B at cycle 5. Required response: unit_a_stb drops after cycle 1, unit_b_stb held with unit_b stable until cycle 5, and WAIT is entered only after B.
- Downstream backpressure: out_ready low for 10 cycles. Required response: out_valid and out_z stable the whole time, in_ready=0, and the next pair is accepted only after the transfer.
- TIMEOUT=8 with a unit that never raises unit_z_stb. Required response: err_timeout pulses once, in_ready=1 the next cycle, op_count unchanged, no out_valid.
- Result transfer on the exact timeout edge. Required response: out_valid=1 and no err_timeout. Also, rst asserted in WAIT: all outputs 0 next cycle and op_count=0.
